mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the accumulator CPU's fetch/load/store traffic. The control unit issues word requests over a valid/ready handshake. The block serves each request from a byte-wide 16Ki x 8 store, two byte cycles per 16-bit word, and returns a held response. It sits between the control unit (initiator) and the storage array, replacing direct single-cycle array access.

## Interface
Parameters:
- DEPTH, 16384, number of bytes in the store; power of two.
- AW, 16, request address width.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store word, 0 = load word.
- req_addr  in  AW  byte address of the word's high byte.
- req_wdata  in  16  store data.
- resp_valid  out  1  response available; held until accepted.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  16  load data; 0 for stores.
- resp_err  out  1  request rejected (see Configuration); 0 otherwise.

## Operation
- States: IDLE, HI, LO, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch addr, wdata and write, then go to HI. Inputs are ignored in every other state.
- HI: access byte at a0 = addr mod DEPTH.
  - Store: write wdata[15:8].
  - Load: capture byte into rdata[15:8].
  - Next state: LO.
- LO: access byte at a1 = (addr+1) mod DEPTH.
  - Store: write wdata[7:0].
  - Load: capture into rdata[7:0].
  - Next state: RESP.
- Byte order is big-endian: word = {mem[a0], mem[a1]}.
- Address wrap: upper address bits beyond log2(DEPTH) are discarded. addr=DEPTH-1 pairs byte DEPTH-1 with byte 0.
- RESP: resp_valid=1, with resp_rdata and resp_err stable. On resp_ready, go to IDLE and drop resp_valid.
- No pipelining: one outstanding request.
- Reset:
  - Outputs: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 in the first cycle after reset deasserts.
  - Memory contents are not cleared.
  - Reset mid-transaction aborts it with no response. A store interrupted after HI leaves the high byte written and the low byte unchanged.
- Simultaneous reset and handshake: reset wins; the request is not accepted.

## Timing
- Accept at edge E0. HI access at E1, LO access at E2. resp_valid=1 in the cycle following E2.
- Minimum request-to-response latency is 3 cycles.
- Response held indefinitely while resp_ready=0.
- Response accepted at edge E3 (or later). req_ready=1 in the following cycle.
- Back-to-back throughput: one word per 4 cycles with resp_ready tied high.
- req_ready is a decode of state only; no combinational path from req_valid.
- resp_rdata and resp_err are registered and change only when entering RESP or on reset.

## Configuration
- Macro: MEM_RESP_ALIGN_CHECK_EN.
- Defined:
  - Odd req_addr (bit 0 = 1) is rejected. Accept at E0 goes straight to RESP, with resp_valid in the next cycle, resp_err=1 and resp_rdata=0.
  - No memory access occurs, including for stores.
  - Even addresses behave as in Operation with resp_err=0.
- Undefined:
  - Any address is accepted, odd addresses included, and pairs bytes a0/a1 as specified.
  - resp_err is tied 0.

## Test plan
- Reset then store 0xBEEF at 0x0010, then load 0x0010 → resp_rdata=0xBEEF, resp_err=0. Byte 0x0010=0xBE, byte 0x0011=0xEF. resp_valid appears 3 cycles after each accept.
- Store 0x1234 at 0x3FFE (wraps at DEPTH=16384). Store 0xA55A at 0x7FFE, which aliases to 0x3FFE. Load 0x3FFE → 0xA55A.
- Load with resp_ready held 0 for 5 cycles → resp_valid and resp_rdata stable throughout. req_ready=0; a concurrent req_valid is not accepted. After resp_ready=1, req_ready=1 next cycle.
- Store 0xFFFF at 0x0020. Assert reset on the cycle after the HI edge. Load 0x0020 → high byte 0xFF, low byte = prior content. No response for the aborted store.
- Odd address 0x0005:
  - With MEM_RESP_ALIGN_CHECK_EN: store 0x1111 → resp_err=1, resp_rdata=0, response one cycle after accept. Bytes 0x0005/0x0006 unchanged.
  - Without the macro: the store writes 0x11 to both bytes and load returns 0x1111.
- Back-to-back loads with resp_ready=1 and req_valid=1 continuously → a new accept every 4 cycles. Reset and req_valid asserted together → no accept.

Source files
------------

// File: rtl/mem_responder.sv
// Word-request responder over a byte-wide store: two byte cycles per 16-bit word, big-endian.
// Optional MEM_RESP_ALIGN_CHECK_EN rejects odd word addresses with resp_err instead of accessing memory.
module mem_responder #(
   parameter int unsigned DEPTH = 16384,
   parameter int unsigned AW    = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [15:0]   req_wdata,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [15:0]   resp_rdata,
   output logic          resp_err
);

   localparam int unsigned IW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, HI, LO, RESP} state_t;

   state_t        state, state_nx;
   logic          accept;
   logic          reject;
   logic [IW-1:0] addr_q;
   logic [IW-1:0] a0, a1;
   logic [15:0]   wdata_q;
   logic          write_q;
   logic [7:0]    rd_hi_q;
   logic [7:0]    mem [DEPTH];

   // Address bits above the store size alias onto the same bytes.
   if (AW > IW) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[AW-1:IW];
   end

   assign a0 = addr_q;
   assign a1 = addr_q + IW'(1);

   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      reject     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept   = 1'b1;
               state_nx = HI;
`ifdef MEM_RESP_ALIGN_CHECK_EN
               if (req_addr[0]) begin
                  reject   = 1'b1;
                  state_nx = RESP;
               end
`endif
            end
         end
         HI:   state_nx = LO;
         LO:   state_nx = RESP;
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Response fields only move when entering RESP, so they stay stable while held.
   always_ff @(posedge clock) begin
      if (reset) begin
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= req_addr[IW-1:0];
            wdata_q <= req_wdata;
            write_q <= req_write;
         end
         if (reject) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
         end
         if (state == HI && !write_q) rd_hi_q <= mem[a0];
         if (state == LO) begin
            resp_rdata <= write_q ? 16'h0000 : {rd_hi_q, mem[a1]};
            resp_err   <= 1'b0;
         end
      end
   end

   // Contents survive reset; reset only suppresses the access in flight.
   always_ff @(posedge clock) begin
      if (!reset && write_q) begin
         if (state == HI) mem[a0] <= wdata_q[15:8];
         if (state == LO) mem[a1] <= wdata_q[7:0];
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; follows MEM_RESP_ALIGN_CHECK_EN if defined.
module tb_mem_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [15:0] resp_rdata;
   logic        resp_err;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   mem_responder #(.DEPTH(16384), .AW(16)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clock = ~clock;

   // Issues one request from IDLE (called just after an edge), returns latency in
   // edges from accept to resp_valid (21 = timed out), then accepts the response.
   task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         output int lat, output logic [15:0] rd, output logic err);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 21) begin
         @(posedge clock); #1;
         lat++;
      end
      rd = resp_rdata; err = resp_err;
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      chk_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else pass_cnt++;
      chk_cnt++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", resp_valid); else pass_cnt++;
      chk_cnt++; if (resp_rdata !== 16'h0000) $display("FAIL reset_rdata got %h exp 0000", resp_rdata); else pass_cnt++;
      chk_cnt++; if (resp_err !== 1'b0) $display("FAIL reset_err got %b exp 0", resp_err); else pass_cnt++;
   endtask

   task automatic test_store_load();
      int lat; logic [15:0] rd; logic err;
      do_req(1'b1, 16'h000E, 16'h0011, lat, rd, err);
      do_req(1'b1, 16'h0012, 16'h0000, lat, rd, err);
      do_req(1'b1, 16'h0010, 16'hBEEF, lat, rd, err);
      chk_cnt++; if (lat !== 3) $display("FAIL store_latency got %0d exp 3", lat); else pass_cnt++;
      chk_cnt++; if (rd !== 16'h0000 || err !== 1'b0) $display("FAIL store_resp got %h/%b exp 0000/0", rd, err); else pass_cnt++;
      do_req(1'b0, 16'h0010, 16'h0000, lat, rd, err);
      chk_cnt++; if (lat !== 3) $display("FAIL load_latency got %0d exp 3", lat); else pass_cnt++;
      chk_cnt++; if (rd !== 16'hBEEF || err !== 1'b0) $display("FAIL load_beef got %h/%b exp beef/0", rd, err); else pass_cnt++;
`ifdef MEM_RESP_ALIGN_CHECK_EN
      do_req(1'b0, 16'h0011, 16'h0000, lat, rd, err);
      chk_cnt++; if (lat !== 1 || rd !== 16'h0000 || err !== 1'b1) $display("FAIL odd_load_reject got %0d/%h/%b exp 1/0000/1", lat, rd, err); else pass_cnt++;
`else
      do_req(1'b0, 16'h000F, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'h11BE) $display("FAIL byte_0010 got %h exp 11be", rd); else pass_cnt++;
      do_req(1'b0, 16'h0011, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'hEF00) $display("FAIL byte_0011 got %h exp ef00", rd); else pass_cnt++;
`endif
   endtask

   task automatic test_wrap();
      int lat; logic [15:0] rd; logic err;
      do_req(1'b1, 16'h3FFE, 16'h1234, lat, rd, err);
      do_req(1'b0, 16'h3FFE, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'h1234) $display("FAIL top_word got %h exp 1234", rd); else pass_cnt++;
      do_req(1'b1, 16'h7FFE, 16'hA55A, lat, rd, err);
      do_req(1'b0, 16'h3FFE, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'hA55A) $display("FAIL alias_7ffe got %h exp a55a", rd); else pass_cnt++;
`ifndef MEM_RESP_ALIGN_CHECK_EN
      do_req(1'b1, 16'h0000, 16'h0000, lat, rd, err);
      do_req(1'b1, 16'h3FFF, 16'h7788, lat, rd, err);
      do_req(1'b0, 16'h0000, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'h8800) $display("FAIL wrap_low_byte got %h exp 8800", rd); else pass_cnt++;
      do_req(1'b0, 16'h3FFE, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'hA577) $display("FAIL wrap_high_byte got %h exp a577", rd); else pass_cnt++;
`endif
   endtask

   task automatic test_backpressure();
      int lat; logic [15:0] rd; logic err;
      int n;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
      @(posedge clock); #1;
      // Competing store held during the wait; it must not be taken.
      req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'h0000;
      n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
      chk_cnt++; if (n !== 2) $display("FAIL bp_latency got %0d exp 2", n); else pass_cnt++;
      for (int c = 0; c < 5; c++) begin
         chk_cnt++; if (resp_valid !== 1'b1 || resp_rdata !== 16'hBEEF) $display("FAIL bp_hold_%0d got %b/%h exp 1/beef", c, resp_valid, resp_rdata); else pass_cnt++;
         chk_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready_%0d got %b exp 0", c, req_ready); else pass_cnt++;
         @(posedge clock); #1;
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
      chk_cnt++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL bp_release got %b/%b exp 1/0", req_ready, resp_valid); else pass_cnt++;
      do_req(1'b0, 16'h0010, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'hBEEF) $display("FAIL bp_no_accept got %h exp beef", rd); else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      int lat; logic [15:0] rd; logic err;
      logic seen;
      do_req(1'b1, 16'h0020, 16'h1122, lat, rd, err);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'hFFFF;
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      chk_cnt++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL abort_state got %b/%b exp 1/0", req_ready, resp_valid); else pass_cnt++;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (resp_valid !== 1'b0) seen = 1'b1;
         @(posedge clock); #1;
      end
      chk_cnt++; if (seen !== 1'b0) $display("FAIL abort_no_resp got %b exp 0", seen); else pass_cnt++;
      do_req(1'b0, 16'h0020, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'hFF22) $display("FAIL abort_partial got %h exp ff22", rd); else pass_cnt++;
   endtask

   task automatic test_odd();
      int lat; logic [15:0] rd; logic err;
      do_req(1'b1, 16'h0004, 16'h00AA, lat, rd, err);
      do_req(1'b1, 16'h0006, 16'hBB00, lat, rd, err);
      do_req(1'b1, 16'h0005, 16'h1111, lat, rd, err);
`ifdef MEM_RESP_ALIGN_CHECK_EN
      chk_cnt++; if (lat !== 1) $display("FAIL odd_latency got %0d exp 1", lat); else pass_cnt++;
      chk_cnt++; if (rd !== 16'h0000 || err !== 1'b1) $display("FAIL odd_err got %h/%b exp 0000/1", rd, err); else pass_cnt++;
      do_req(1'b0, 16'h0004, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'h00AA || err !== 1'b0) $display("FAIL odd_byte5 got %h/%b exp 00aa/0", rd, err); else pass_cnt++;
      do_req(1'b0, 16'h0006, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'hBB00) $display("FAIL odd_byte6 got %h exp bb00", rd); else pass_cnt++;
`else
      chk_cnt++; if (lat !== 3 || err !== 1'b0) $display("FAIL odd_store got %0d/%b exp 3/0", lat, err); else pass_cnt++;
      do_req(1'b0, 16'h0005, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'h1111 || err !== 1'b0) $display("FAIL odd_load got %h/%b exp 1111/0", rd, err); else pass_cnt++;
      do_req(1'b0, 16'h0004, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'h0011) $display("FAIL odd_byte5 got %h exp 0011", rd); else pass_cnt++;
      do_req(1'b0, 16'h0006, 16'h0000, lat, rd, err);
      chk_cnt++; if (rd !== 16'h1100) $display("FAIL odd_byte6 got %h exp 1100", rd); else pass_cnt++;
`endif
   endtask

   task automatic test_back_to_back();
      int prev;
      int naccept;
      int n;
      resp_ready = 1'b1;
      req_write = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
      prev = -1; naccept = 0;
      for (int c = 0; c < 16; c++) begin
         if (req_ready === 1'b1) begin
            if (prev >= 0) begin
               chk_cnt++; if (c - prev !== 4) $display("FAIL b2b_spacing got %0d exp 4", c - prev); else pass_cnt++;
            end
            prev = c;
            naccept++;
         end
         if (resp_valid === 1'b1) begin
            chk_cnt++; if (resp_rdata !== 16'hBEEF) $display("FAIL b2b_rdata got %h exp beef", resp_rdata); else pass_cnt++;
         end
         @(posedge clock); #1;
      end
      chk_cnt++; if (naccept !== 4) $display("FAIL b2b_count got %0d exp 4", naccept); else pass_cnt++;
      req_valid = 1'b0;
      n = 0;
      while (!(req_ready === 1'b1 && resp_valid === 1'b0) && n < 10) begin @(posedge clock); #1; n++; end
      chk_cnt++; if (n >= 10) $display("FAIL b2b_drain got timeout exp idle"); else pass_cnt++;
      resp_ready = 1'b0;
      // Reset and request on the same edge: the request must be dropped.
      reset = 1'b1; req_valid = 1'b1; req_addr = 16'h0010;
      @(posedge clock); #1;
      reset = 1'b0; req_valid = 1'b0;
      chk_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_vs_req got req_ready=%b exp 1", req_ready); else pass_cnt++;
      repeat (3) @(posedge clock);
      #1;
      chk_cnt++; if (resp_valid !== 1'b0) $display("FAIL rst_vs_req_resp got %b exp 0", resp_valid); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_wrap();
      test_backpressure();
      test_reset_abort();
      test_odd();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
